// File: rtl/alu_seq_ctrl.sv
// Sequential front-end for a 16-bit ALU: registered request/response handshakes,
// a programmable settle interval, chained carry/borrow state and sticky flags.

package alu_seq_pkg;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MUL  = 5'd2;
  localparam logic [4:0] ALU_DIV  = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOT  = 5'd7;
  localparam logic [4:0] ALU_SHL  = 5'd8;
  localparam logic [4:0] ALU_SHR  = 5'd9;
  localparam logic [4:0] ALU_INC  = 5'd10;
  localparam logic [4:0] ALU_DEC  = 5'd11;
  localparam logic [4:0] ALU_PASS = 5'd12;

  // Flag vector bit positions: {ET, LT, GT, divbyzero, overflow, borrowout, carryout, negative, zero}.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_CO   = 2;
  localparam int FLAG_BO   = 3;
  localparam int FLAG_OVF  = 4;
  localparam int FLAG_DBZ  = 5;
  localparam int FLAG_GT   = 6;
  localparam int FLAG_LT   = 7;
  localparam int FLAG_ET   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

module alu_top
  import alu_seq_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryin,
  input  logic        borrowin,
  output logic [15:0] alu_out,
  output logic [15:0] upper_alubits,
  output logic [15:0] remainder_alubits,
  output logic        et,
  output logic        lt,
  output logic        gt,
  output logic        divbyzero,
  output logic        overflow,
  output logic        borrowout,
  output logic        carryout,
  output logic        negative,
  output logic        zero
);
  logic [16:0] sum;
  logic [16:0] diff;
  logic [31:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b} + {16'd0, carryin};
  assign diff = {1'b0, a} - {1'b0, b} - {16'd0, borrowin};
  assign prod = {16'd0, a} * {16'd0, b};

  // NOTE: every output gets a default before the case, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    alu_out           = '0;
    upper_alubits     = '0;
    remainder_alubits = '0;
    divbyzero         = 1'b0;
    overflow          = 1'b0;
    borrowout         = 1'b0;
    carryout          = 1'b0;
    unique case (op)
      ALU_ADD: begin
        alu_out  = sum[15:0];
        carryout = sum[16];
        overflow = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      ALU_SUB: begin
        alu_out   = diff[15:0];
        borrowout = diff[16];
        overflow  = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      ALU_MUL: begin
        alu_out       = prod[15:0];
        upper_alubits = prod[31:16];
        overflow      = |prod[31:16];
      end
      ALU_DIV: begin
        // Divide by zero saturates the quotient and returns the dividend as remainder.
        if (b == 16'd0) begin
          alu_out           = 16'hFFFF;
          remainder_alubits = a;
          divbyzero         = 1'b1;
        end else begin
          alu_out           = a / b;
          remainder_alubits = a % b;
        end
      end
      ALU_AND:  alu_out = a & b;
      ALU_OR:   alu_out = a | b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_NOT:  alu_out = ~a;
      ALU_SHL:  alu_out = a << b[3:0];
      ALU_SHR:  alu_out = a >> b[3:0];
      ALU_INC:  alu_out = a + 16'd1;
      ALU_DEC:  alu_out = a - 16'd1;
      ALU_PASS: alu_out = a;
      default:  alu_out = '0;
    endcase
  end

  assign et       = (a == b);
  assign lt       = (a < b);
  assign gt       = (a > b);
  assign negative = alu_out[15];
  assign zero     = (alu_out == 16'd0);
endmodule

module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1  // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_chain,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_upper,
  output logic [15:0] rsp_rem,
  output logic [8:0]  rsp_flags,
  output logic [8:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        carry_q,
  output logic        borrow_q,
  output logic        busy
);
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        bin_q, bin_d;
  logic [15:0] result_q, result_d;
  logic [15:0] upper_q, upper_d;
  logic [15:0] rem_q, rem_d;
  logic [8:0]  flags_q, flags_d;
  logic [8:0]  sticky_q, sticky_d;
  logic        carry_d, borrow_d;

  logic [15:0] alu_out, alu_upper, alu_rem;
  logic        f_et, f_lt, f_gt, f_dbz, f_ovf, f_bo, f_co, f_neg, f_zero;
  logic [8:0]  alu_flags;

  alu_top u_alu (
    .op                (op_q),
    .a                 (a_q),
    .b                 (b_q),
    .carryin           (cin_q),
    .borrowin          (bin_q),
    .alu_out           (alu_out),
    .upper_alubits     (alu_upper),
    .remainder_alubits (alu_rem),
    .et                (f_et),
    .lt                (f_lt),
    .gt                (f_gt),
    .divbyzero         (f_dbz),
    .overflow          (f_ovf),
    .borrowout         (f_bo),
    .carryout          (f_co),
    .negative          (f_neg),
    .zero              (f_zero)
  );

  assign alu_flags = {f_et, f_lt, f_gt, f_dbz, f_ovf, f_bo, f_co, f_neg, f_zero};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    bin_d    = bin_q;
    result_d = result_q;
    upper_d  = upper_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    // A clear alone empties the sticky register; a capture on the same edge ORs on top.
    sticky_d = sticky_clr ? 9'd0 : sticky_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_chain & carry_q;
          bin_d   = req_chain & borrow_q;
          cnt_d   = CNT_LOAD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = alu_out;
          upper_d  = alu_upper;
          rem_d    = alu_rem;
          flags_d  = alu_flags;
          sticky_d = sticky_d | alu_flags;
          if (op_q == ALU_ADD) carry_d  = f_co;
          if (op_q == ALU_SUB) borrow_d = f_bo;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      bin_q    <= 1'b0;
      result_q <= '0;
      upper_q  <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      bin_q    <= bin_d;
      result_q <= result_d;
      upper_q  <= upper_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Handshake outputs come from registered state; rst only gates acceptance.
  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q == S_EXEC) || (state_q == S_RESP);
  assign rsp_result   = result_q;
  assign rsp_upper    = upper_q;
  assign rsp_rem      = rem_q;
  assign rsp_flags    = flags_q;
  assign sticky_flags = sticky_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance at EXEC_CYCLES=1, one at 4 for
// latency and mid-operation reset.

module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // EXEC_CYCLES = 1 instance
  logic        rst, req_valid, req_chain, rsp_ready, sticky_clr;
  logic [4:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_ready, rsp_valid, carry_o, borrow_o, busy;
  logic [15:0] rsp_result, rsp_upper, rsp_rem;
  logic [8:0]  rsp_flags, sticky_flags;

  // EXEC_CYCLES = 4 instance
  logic        rst4, req_valid4, req_chain4, rsp_ready4, sticky_clr4;
  logic [4:0]  req_op4;
  logic [15:0] req_a4, req_b4;
  logic        req_ready4, rsp_valid4, carry4, borrow4, busy4;
  logic [15:0] rsp_result4, rsp_upper4, rsp_rem4;
  logic [8:0]  rsp_flags4, sticky4;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_upper(rsp_upper), .rsp_rem(rsp_rem), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .carry_q(carry_o), .borrow_q(borrow_o), .busy(busy)
  );

  alu_seq_ctrl #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op4), .req_a(req_a4), .req_b(req_b4), .req_chain(req_chain4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_upper(rsp_upper4), .rsp_rem(rsp_rem4), .rsp_flags(rsp_flags4),
    .sticky_flags(sticky4), .sticky_clr(sticky_clr4),
    .carry_q(carry4), .borrow_q(borrow4), .busy(busy4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for rsp_valid; lat is the expected edge count
  // after the accept edge. sclr raises sticky_clr on the capture edge of dut.
  task automatic run_op(input bit u4, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic chain, input bit sclr,
                        input int lat);
    int edges;
    if (u4) begin
      req_valid4 = 1'b1; req_op4 = op; req_a4 = a; req_b4 = b; req_chain4 = chain;
    end else begin
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_chain = chain;
    end
    tick();
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    sticky_clr = sclr;
    edges = 0;
    while (!(u4 ? rsp_valid4 : rsp_valid) && edges < 30) begin
      tick();
      sticky_clr = 1'b0;
      edges++;
    end
    sticky_clr = 1'b0;
    check("latency", edges, lat);
  endtask

  task automatic chk_rsp(input bit u4, input logic [15:0] res, input logic [15:0] up,
                         input logic [15:0] rem, input logic [8:0] flg,
                         input logic [8:0] stk, input logic cy, input logic bw);
    if (u4) begin
      check("result4", rsp_result4, res);
      check("upper4",  rsp_upper4,  up);
      check("rem4",    rsp_rem4,    rem);
      check("flags4",  rsp_flags4,  flg);
      check("sticky4", sticky4,     stk);
      check("carry4",  carry4,      cy);
      check("borrow4", borrow4,     bw);
    end else begin
      check("result", rsp_result,   res);
      check("upper",  rsp_upper,    up);
      check("rem",    rsp_rem,      rem);
      check("flags",  rsp_flags,    flg);
      check("sticky", sticky_flags, stk);
      check("carry",  carry_o,      cy);
      check("borrow", borrow_o,     bw);
    end
  endtask

  task automatic consume(input bit u4);
    if (u4) rsp_ready4 = 1'b1; else rsp_ready = 1'b1;
    tick();
    rsp_ready  = 1'b0;
    rsp_ready4 = 1'b0;
    check("ready_after_consume", u4 ? req_ready4 : req_ready, 1'b1);
    check("valid_after_consume", u4 ? rsp_valid4 : rsp_valid, 1'b0);
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1; req_valid = 1'b0; req_chain = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    rst4 = 1'b1; req_valid4 = 1'b0; req_chain4 = 1'b0; rsp_ready4 = 1'b0; sticky_clr4 = 1'b0;
    req_op4 = '0; req_a4 = '0; req_b4 = '0;

    // Reset state
    tick(); tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    chk_rsp(0, 16'd0, 16'd0, 16'd0, 9'h000, 9'h000, 1'b0, 1'b0);
    check("rst_req_ready4", req_ready4, 1'b0);
    rst = 1'b0; rst4 = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_req_ready4", req_ready4, 1'b1);

    // ADD 10+5
    run_op(0, ALU_ADD, 16'd10, 16'd5, 1'b0, 1'b0, 1);
    check("resp_busy", busy, 1'b1);
    chk_rsp(0, 16'd15, 16'd0, 16'd0, 9'h040, 9'h040, 1'b0, 1'b0);
    consume(0);

    // Chained add: 65535+1 then 0+0 with carry in
    run_op(0, ALU_ADD, 16'hFFFF, 16'd1, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd0, 16'd0, 16'd0, 9'h045, 9'h045, 1'b1, 1'b0);
    consume(0);
    run_op(0, ALU_ADD, 16'd0, 16'd0, 1'b1, 1'b0, 1);
    chk_rsp(0, 16'd1, 16'd0, 16'd0, 9'h100, 9'h145, 1'b0, 1'b0);
    consume(0);

    // Set carry again, then MUL must leave it alone
    run_op(0, ALU_ADD, 16'hFFFF, 16'd1, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd0, 16'd0, 16'd0, 9'h045, 9'h145, 1'b1, 1'b0);
    consume(0);
    run_op(0, ALU_MUL, 16'd3, 16'd4, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd12, 16'd0, 16'd0, 9'h080, 9'h1C5, 1'b1, 1'b0);
    consume(0);

    // DIV and sticky
    run_op(0, ALU_DIV, 16'd103, 16'd10, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd10, 16'd0, 16'd3, 9'h040, 9'h1C5, 1'b1, 1'b0);
    consume(0);
    run_op(0, ALU_DIV, 16'd100, 16'd0, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'hFFFF, 16'd0, 16'd100, 9'h062, 9'h1E7, 1'b1, 1'b0);
    check("sticky_dbz", sticky_flags[FLAG_DBZ], 1'b1);
    check("sticky_bit6", sticky_flags[6], 1'b1);
    consume(0);
    run_op(0, ALU_ADD, 16'd1, 16'd1, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd2, 16'd0, 16'd0, 9'h100, 9'h1E7, 1'b0, 1'b0);
    consume(0);
    check("sticky_dbz_persist", sticky_flags[FLAG_DBZ], 1'b1);

    // sticky_clr pulse while idle
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared", sticky_flags, 9'h000);

    // Clear coinciding with a DIV-by-0 capture leaves only the new flags
    run_op(0, ALU_ADD, 16'd1, 16'd1, 1'b0, 1'b0, 1);
    chk_rsp(0, 16'd2, 16'd0, 16'd0, 9'h100, 9'h100, 1'b0, 1'b0);
    consume(0);
    run_op(0, ALU_DIV, 16'd7, 16'd0, 1'b0, 1'b1, 1);
    chk_rsp(0, 16'hFFFF, 16'd0, 16'd7, 9'h062, 9'h062, 1'b0, 1'b0);
    consume(0);

    // Backpressure: MUL 200*200 held for 5 cycles, stray request ignored
    run_op(0, ALU_MUL, 16'd200, 16'd200, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_op = ALU_ADD; req_a = 16'd1; req_b = 16'd1;
      end
      tick();
      req_valid = 1'b0;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
      check("bp_result", rsp_result, 16'd40000);
      check("bp_upper", rsp_upper, 16'd0);
    end
    check("bp_flags", rsp_flags, 9'h102);
    check("bp_sticky", sticky_flags, 9'h162);
    consume(0);
    check("bp_idle_busy", busy, 1'b0);
    check("bp_hold_after", rsp_result, 16'd40000);
    tick();
    check("bp_no_ghost", busy, 1'b0);

    // EXEC_CYCLES=4: latency, then reset mid-operation
    run_op(1, ALU_ADD, 16'hFFFF, 16'd1, 1'b0, 1'b0, 4);
    chk_rsp(1, 16'd0, 16'd0, 16'd0, 9'h045, 9'h045, 1'b1, 1'b0);
    consume(1);
    req_valid4 = 1'b1; req_op4 = ALU_ADD; req_a4 = 16'd2; req_b4 = 16'd3; req_chain4 = 1'b0;
    tick();
    req_valid4 = 1'b0;
    tick();
    check("mid_busy4", busy4, 1'b1);
    rst4 = 1'b1;
    #1;
    check("mid_rst_ready4", req_ready4, 1'b0);
    tick();
    check("mid_rst_valid4", rsp_valid4, 1'b0);
    check("mid_rst_busy4", busy4, 1'b0);
    chk_rsp(1, 16'd0, 16'd0, 16'd0, 9'h000, 9'h000, 1'b0, 1'b0);
    rst4 = 1'b0;
    #1;
    check("post_rst_ready4", req_ready4, 1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid4) seen_valid = 1'b1;
    end
    check("no_rsp_after_rst4", seen_valid, 1'b0);

    run_op(1, ALU_SUB, 16'd5, 16'd10, 1'b0, 1'b0, 4);
    chk_rsp(1, 16'hFFFB, 16'd0, 16'd0, 9'h08A, 9'h08A, 1'b0, 1'b1);
    consume(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
